// File: rtl/pcie_msi_irq_ctrl_pkg.sv
// Shared types for the PCIe MSI interrupt controller: FSM states, vector limit
// and the MMEnable-to-vector-count decode.
package pcie_msi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } msi_state_e;

    localparam int MSI_MAX_VEC = 32;

    // MMEnable encodes log2 of the granted vector count; codes above 5 still mean 32.
    function automatic logic [5:0] msi_alloc(input logic [2:0] mmenable3);
        if (mmenable3 >= 3'd5) begin
            return 6'd32;
        end
        return 6'd1 << mmenable3;
    endfunction

endpackage

// File: rtl/pcie_msi_irq_ctrl_arbiter.sv
// Round-robin picker: first set request bit at or after the pointer, wrapping.
// Purely combinational; the parent registers the grant.
module pcie_msi_rr_arbiter
    import pcie_msi_pkg::*;
(
    input  logic [MSI_MAX_VEC-1:0] req,
    input  logic [4:0]             ptr,
    output logic [4:0]             grant,
    output logic                   valid
);

    logic [4:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < MSI_MAX_VEC; i++) begin
            idx = ptr + 5'(i);
            if (!valid && req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcie_msi_irq_ctrl.sv
// MSI interrupt controller in front of the PCIe4 cfg_interrupt_msi_* port.
// Optional per-vector holdoff (coalescing) is built when MSI_COALESCE_EN is defined.
module pcie_msi_irq_ctrl
    import pcie_msi_pkg::*;
#(
    parameter int IRQ_COUNT     = 32,
    parameter int MSI_FUNC      = 0,
    parameter int RETRY_MAX     = 3,
    parameter int HOLDOFF_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [IRQ_COUNT-1:0]     irq_req,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff_cycles,
    input  logic [3:0]               cfg_interrupt_msi_enable,
    input  logic [11:0]              cfg_interrupt_msi_mmenable,
    output logic [31:0]              cfg_interrupt_msi_int,
    input  logic                     cfg_interrupt_msi_sent,
    input  logic                     cfg_interrupt_msi_fail,
    output logic [31:0]              cfg_interrupt_msi_pending_status,
    output logic                     cfg_interrupt_msi_pending_status_data_enable,
    output logic [3:0]               cfg_interrupt_msi_pending_status_function_num,
    output logic [3:0]               cfg_interrupt_msi_select,
    output logic [3:0]               cfg_interrupt_msi_function_number,
    output logic [2:0]               cfg_interrupt_msi_attr,
    output logic                     cfg_interrupt_msi_tph_present,
    output logic [1:0]               cfg_interrupt_msi_tph_type,
    output logic [8:0]               cfg_interrupt_msi_tph_st_tag,
    output logic [15:0]              irq_drop_count,
    output msi_state_e               dbg_state
);

    msi_state_e             state_q, state_d;
    logic [4:0]             vec_q, vec_d;
    logic [4:0]             ptr_q, ptr_d;
    logic [3:0]             retry_q, retry_d;
    logic [15:0]            drop_q, drop_d;
    logic [MSI_MAX_VEC-1:0] pending_q, pending_d;
    logic                   data_en_q, data_en_d;

    logic [5:0]             alloc;
    logic [4:0]             vec_mask;
    logic [MSI_MAX_VEC-1:0] alloc_mask;
    logic [MSI_MAX_VEC-1:0] set_vec;
    logic [MSI_MAX_VEC-1:0] clr_vec;
    logic [MSI_MAX_VEC-1:0] hold_busy;
    logic [MSI_MAX_VEC-1:0] eligible;
    logic                   sent_evt;
    logic [4:0]             arb_grant;
    logic                   arb_valid;
    logic                   unused_cfg;

    assign alloc    = msi_alloc(cfg_interrupt_msi_mmenable[MSI_FUNC*3 +: 3]);
    assign vec_mask = 5'(alloc - 6'd1);
    assign unused_cfg = ^{cfg_interrupt_msi_enable, cfg_interrupt_msi_mmenable};

    // Sources fold onto the granted vectors; vectors outside the grant stay pending but unselectable.
    always_comb begin
        set_vec    = '0;
        alloc_mask = '0;
        for (int v = 0; v < MSI_MAX_VEC; v++) begin
            alloc_mask[v] = (6'(v) < alloc);
        end
        for (int i = 0; i < IRQ_COUNT; i++) begin
            if (irq_req[i]) begin
                set_vec[5'(i) & vec_mask] = 1'b1;
            end
        end
    end

    assign eligible = pending_q & alloc_mask & ~hold_busy;

    pcie_msi_rr_arbiter u_arb (
        .req   (eligible),
        .ptr   (ptr_q & vec_mask),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        ptr_d    = ptr_q;
        retry_d  = retry_q;
        drop_d   = drop_q;
        clr_vec  = '0;
        sent_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_interrupt_msi_enable[MSI_FUNC] && arb_valid) begin
                    vec_d   = arb_grant;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // sent wins when the core reports both in the same cycle
                if (cfg_interrupt_msi_sent) begin
                    clr_vec[vec_q] = 1'b1;
                    retry_d        = '0;
                    ptr_d          = (vec_q + 5'd1) & vec_mask;
                    sent_evt       = 1'b1;
                    state_d        = IDLE;
                end else if (cfg_interrupt_msi_fail) begin
                    if (retry_q == 4'(RETRY_MAX - 1)) begin
                        clr_vec[vec_q] = 1'b1;
                        retry_d        = '0;
                        if (drop_q != 16'hFFFF) begin
                            drop_d = drop_q + 16'd1;
                        end
                    end else begin
                        retry_d = retry_q + 4'd1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        pending_d = (pending_q & ~clr_vec) | set_vec;
        data_en_d = (pending_d != pending_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            ptr_q     <= '0;
            retry_q   <= '0;
            drop_q    <= '0;
            pending_q <= '0;
            data_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            ptr_q     <= ptr_d;
            retry_q   <= retry_d;
            drop_q    <= drop_d;
            pending_q <= pending_d;
            data_en_q <= data_en_d;
        end
    end

`ifdef MSI_COALESCE_EN
    logic [HOLDOFF_WIDTH-1:0] hold_q [MSI_MAX_VEC];
    logic [HOLDOFF_WIDTH-1:0] hold_d [MSI_MAX_VEC];

    always_comb begin
        for (int v = 0; v < MSI_MAX_VEC; v++) begin
            hold_d[v]    = hold_q[v];
            hold_busy[v] = (hold_q[v] != '0);
            if (sent_evt && (vec_q == 5'(v))) begin
                hold_d[v] = holdoff_cycles;
            end else if (hold_q[v] != '0) begin
                hold_d[v] = hold_q[v] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < MSI_MAX_VEC; v++) begin
                hold_q[v] <= '0;
            end
        end else begin
            for (int v = 0; v < MSI_MAX_VEC; v++) begin
                hold_q[v] <= hold_d[v];
            end
        end
    end
`else
    logic unused_holdoff;
    assign unused_holdoff = ^{holdoff_cycles, sent_evt};
    assign hold_busy      = '0;
`endif

    assign cfg_interrupt_msi_int = (state_q == ISSUE) ? (32'd1 << vec_q) : 32'd0;
    assign cfg_interrupt_msi_pending_status              = pending_q;
    assign cfg_interrupt_msi_pending_status_data_enable  = data_en_q;
    assign cfg_interrupt_msi_pending_status_function_num = 4'(MSI_FUNC);
    assign cfg_interrupt_msi_select                      = 4'(MSI_FUNC);
    assign cfg_interrupt_msi_function_number             = 4'(MSI_FUNC);
    assign cfg_interrupt_msi_attr                        = '0;
    assign cfg_interrupt_msi_tph_present                 = 1'b0;
    assign cfg_interrupt_msi_tph_type                    = '0;
    assign cfg_interrupt_msi_tph_st_tag                  = '0;
    assign irq_drop_count                                = drop_q;
    assign dbg_state                                     = state_q;

endmodule

// File: tb/tb_pcie_msi_irq_ctrl.sv
// Directed bench for pcie_msi_irq_ctrl: expected MSI vectors are queued when a
// request is driven and compared when the core-side pulse appears.
module tb_pcie_msi_irq_ctrl;
    import pcie_msi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] irq_req = '0;
    logic [15:0] holdoff_cycles = 16'd100;
    logic [3:0]  msi_enable = 4'h1;
    logic [11:0] msi_mmenable = 12'h005;
    logic        msi_sent = 1'b0;
    logic        msi_fail = 1'b0;
    logic [31:0] msi_int;
    logic [31:0] pending_status;
    logic        pending_de;
    logic [3:0]  pending_fn;
    logic [3:0]  msi_select;
    logic [3:0]  msi_fn;
    logic [2:0]  msi_attr;
    logic        tph_present;
    logic [1:0]  tph_type;
    logic [8:0]  tph_st_tag;
    logic [15:0] drop_count;
    msi_state_e  dbg_state;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          exp_pulses = 0;
    int          seen_pulses = 0;
    logic [31:0] exp_q[$];

    always #2 clk = ~clk;

    pcie_msi_irq_ctrl dut (
        .clk                                           (clk),
        .rst_n                                         (rst_n),
        .irq_req                                       (irq_req),
        .holdoff_cycles                                (holdoff_cycles),
        .cfg_interrupt_msi_enable                      (msi_enable),
        .cfg_interrupt_msi_mmenable                    (msi_mmenable),
        .cfg_interrupt_msi_int                         (msi_int),
        .cfg_interrupt_msi_sent                        (msi_sent),
        .cfg_interrupt_msi_fail                        (msi_fail),
        .cfg_interrupt_msi_pending_status              (pending_status),
        .cfg_interrupt_msi_pending_status_data_enable  (pending_de),
        .cfg_interrupt_msi_pending_status_function_num (pending_fn),
        .cfg_interrupt_msi_select                      (msi_select),
        .cfg_interrupt_msi_function_number             (msi_fn),
        .cfg_interrupt_msi_attr                        (msi_attr),
        .cfg_interrupt_msi_tph_present                 (tph_present),
        .cfg_interrupt_msi_tph_type                    (tph_type),
        .cfg_interrupt_msi_tph_st_tag                  (tph_st_tag),
        .irq_drop_count                                (drop_count),
        .dbg_state                                     (dbg_state)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && msi_int != 32'd0) seen_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_pulse(input logic [31:0] v);
        exp_q.push_back(v);
        exp_pulses++;
    endtask

    task automatic pulse_req(input logic [31:0] m);
        irq_req = m;
        @(negedge clk);
        irq_req = '0;
    endtask

    task automatic wait_pulse(input string tag, input int budget, output int lat);
        logic [31:0] e;
        lat = 0;
        while (msi_int == 32'd0 && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        e = (exp_q.size() == 0) ? 32'd0 : exp_q.pop_front();
        chk(tag, msi_int, e);
    endtask

    task automatic respond(input logic s, input logic f);
        @(negedge clk);
        chk("pulse_one_cycle", msi_int, 32'd0);
        msi_sent = s;
        msi_fail = f;
        @(negedge clk);
        msi_sent = 1'b0;
        msi_fail = 1'b0;
    endtask

    initial begin
        int lat;
        int t_sent;

        // reset
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_msi_int", msi_int, 32'd0);
        chk("rst_pending", pending_status, 32'd0);
        chk("rst_data_en", 32'(pending_de), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_fn_outs", {20'd0, pending_fn, msi_select, msi_fn}, 32'd0);
        chk("rst_tied", {17'd0, msi_attr, tph_present, tph_type, tph_st_tag}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single vector, latency and pending status mirror
        expect_pulse(32'h8);
        irq_req = 32'h8;
        @(negedge clk);
        irq_req = '0;
        chk("t1_pending_set", pending_status, 32'h8);
        chk("t1_de_set", 32'(pending_de), 32'd1);
        wait_pulse("t1_pulse", 10, lat);
        chk("t1_latency", 32'(lat), 32'd1);
        chk("t1_de_idle", 32'(pending_de), 32'd0);
        chk("t1_pending_held", pending_status, 32'h8);
        respond(1'b1, 1'b0);
        chk("t1_pending_clr", pending_status, 32'd0);
        chk("t1_de_clr", 32'(pending_de), 32'd1);
        @(negedge clk);
        chk("t1_de_low", 32'(pending_de), 32'd0);

        // round-robin order then wrap from ptr=3
        expect_pulse(32'h1);
        expect_pulse(32'h2);
        expect_pulse(32'h4);
        pulse_req(32'h7);
        wait_pulse("t2_v0", 10, lat);
        respond(1'b1, 1'b0);
        wait_pulse("t2_v1", 10, lat);
        respond(1'b1, 1'b1);
        wait_pulse("t2_v2", 10, lat);
        respond(1'b1, 1'b0);
        chk("t2_pending_empty", pending_status, 32'd0);
        expect_pulse(32'h1);
        expect_pulse(32'h4);
        pulse_req(32'h5);
        wait_pulse("t2_wrap_v0", 10, lat);
        respond(1'b1, 1'b0);
        wait_pulse("t2_wrap_v2", 10, lat);
        respond(1'b1, 1'b0);

        // two granted vectors: sources fold
        msi_mmenable = 12'h001;
        expect_pulse(32'h2);
        pulse_req(32'h20);
        wait_pulse("t3_src5", 10, lat);
        respond(1'b1, 1'b0);
        expect_pulse(32'h1);
        pulse_req(32'h10);
        wait_pulse("t3_src4", 10, lat);
        respond(1'b1, 1'b0);
        msi_mmenable = 12'h005;

        // retry limit and drop counter
        repeat (3) expect_pulse(32'h80);
        pulse_req(32'h80);
        for (int k = 0; k < 3; k++) begin
            wait_pulse("t4_retry", 10, lat);
            respond(1'b0, 1'b1);
        end
        chk("t4_pending_dropped", pending_status, 32'd0);
        chk("t4_drop1", 32'(drop_count), 32'd1);
        repeat (4) @(negedge clk);
        chk("t4_no_extra", 32'(seen_pulses), 32'(exp_pulses));
        expect_pulse(32'h80);
        expect_pulse(32'h80);
        pulse_req(32'h80);
        wait_pulse("t4_fail_once", 10, lat);
        respond(1'b0, 1'b1);
        wait_pulse("t4_then_sent", 10, lat);
        respond(1'b1, 1'b0);
        chk("t4_drop_kept", 32'(drop_count), 32'd1);
        chk("t4_pending_clr", pending_status, 32'd0);

        // enable gating
        msi_enable = 4'h0;
        pulse_req(32'h200);
        repeat (6) @(negedge clk);
        chk("t5_pending_latched", pending_status, 32'h200);
        chk("t5_no_pulse", 32'(seen_pulses), 32'(exp_pulses));
        expect_pulse(32'h200);
        msi_enable = 4'h1;
        wait_pulse("t5_after_enable", 10, lat);
        respond(1'b1, 1'b0);

        // re-request shortly after sent
        expect_pulse(32'h2);
        pulse_req(32'h2);
        wait_pulse("t6_first", 10, lat);
        respond(1'b1, 1'b0);
        t_sent = cyc;
        repeat (9) @(negedge clk);
        expect_pulse(32'h2);
        pulse_req(32'h2);
        wait_pulse("t6_second", 300, lat);
`ifdef MSI_COALESCE_EN
        chk("t6_holdoff_gap", 32'((cyc - t_sent) >= 100), 32'd1);
`else
        chk("t6_latency", 32'(lat), 32'd1);
`endif
        respond(1'b1, 1'b0);

        // async reset while waiting for the core, late sent ignored
        expect_pulse(32'h4);
        pulse_req(32'h4);
        wait_pulse("t7_pulse", 10, lat);
        @(negedge clk);
        chk("t7_in_wait", 32'(dbg_state), 32'(WAIT));
        #1 rst_n = 1'b0;
        #1;
        chk("t7_rst_state", 32'(dbg_state), 32'(IDLE));
        chk("t7_rst_pending", pending_status, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        msi_sent = 1'b1;
        @(negedge clk);
        msi_sent = 1'b0;
        chk("t7_late_sent_state", 32'(dbg_state), 32'(IDLE));
        chk("t7_late_sent_pending", pending_status, 32'd0);
        repeat (4) @(negedge clk);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("pulse_total", 32'(seen_pulses), 32'(exp_pulses));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
